// File: rtl/echo_delay_ctrl.sv
// Single-tap feedback echo around an external dual-port delay-line RAM with 2-cycle read latency.
// Define ECHO_SATURATE_EN to clamp the dry+wet sum; otherwise the sum wraps to DATA_WIDTH bits.
module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] SAMPLE_IN,
  input  logic                  IN_VALID,
  input  logic [ADDR_WIDTH-1:0] DELAY,
  input  logic [3:0]            FEEDBACK,
  output logic [DATA_WIDTH-1:0] SAMPLE_OUT,
  output logic                  OUT_VALID,
  output logic                  BUSY,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_WADDR,
  output logic [ADDR_WIDTH-1:0] MEM_RADDR,
  output logic [DATA_WIDTH-1:0] MEM_DI,
  input  logic [DATA_WIDTH-1:0] MEM_DO
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int PW  = DATA_WIDTH + 5;
  localparam logic [AW1-1:0] SIZE_W = AW1'(SIZE);
  localparam logic [AW1-1:0] LAST_W = AW1'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, RD, WAIT1, WAIT2, WR} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] sample_q, sample_out_q, mem_di_q;
  logic [3:0]            fb_q;
  logic [AW1-1:0]        d_q, wptr_q, fill_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_raddr_q;
  logic                  out_valid_q, mem_we_q;

  logic [AW1-1:0]               delay_w, d_eff, raddr_sum, raddr_d;
  logic signed [DATA_WIDTH-1:0] ds;
  logic signed [PW-1:0]         prod, wet, sum_full;
  logic signed [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0]        result;
  logic                         unused_bits;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    BUSY    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (IN_VALID) state_d = RD;
      RD:      state_d = WAIT1;
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Effective delay is kept in 1..SIZE-1 so the read tap never lands on the write slot.
  assign delay_w = {1'b0, DELAY};
  always_comb begin
    d_eff = delay_w;
    if (delay_w == '0)          d_eff = AW1'(1);
    else if (delay_w >= SIZE_W) d_eff = LAST_W;
  end

  assign raddr_sum = wptr_q + SIZE_W - d_eff;
  assign raddr_d   = (raddr_sum >= SIZE_W) ? raddr_sum - SIZE_W : raddr_sum;

  // Taps older than the number of samples written so far hold stale RAM contents.
  assign ds       = (fill_q < d_q) ? '0 : $signed(MEM_DO);
  assign prod     = PW'(ds) * PW'($signed({1'b0, fb_q}));
  assign wet      = prod >>> 4;
  assign sum_full = PW'($signed(sample_q)) + wet;
  assign sum      = sum_full[DATA_WIDTH:0];

  always_comb begin
    result = sum[DATA_WIDTH-1:0];
`ifdef ECHO_SATURATE_EN
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      result = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
  end

  assign unused_bits = ^{sum_full[PW-1:DATA_WIDTH+1], sum[DATA_WIDTH], raddr_d[AW1-1]};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sample_q     <= '0;
      fb_q         <= '0;
      d_q          <= '0;
      wptr_q       <= '0;
      fill_q       <= '0;
      sample_out_q <= '0;
      mem_di_q     <= '0;
      mem_waddr_q  <= '0;
      mem_raddr_q  <= '0;
      out_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      if (state_q == IDLE && IN_VALID) begin
        sample_q    <= SAMPLE_IN;
        fb_q        <= FEEDBACK;
        d_q         <= d_eff;
        mem_raddr_q <= raddr_d[ADDR_WIDTH-1:0];
      end
      // Read data is valid during WAIT2; register the mix so it appears in WR.
      if (state_q == WAIT2) begin
        sample_out_q <= result;
        mem_di_q     <= result;
        mem_waddr_q  <= wptr_q[ADDR_WIDTH-1:0];
        out_valid_q  <= 1'b1;
        mem_we_q     <= 1'b1;
      end
      if (state_q == WR) begin
        wptr_q <= (wptr_q == LAST_W) ? '0 : wptr_q + AW1'(1);
        if (fill_q != SIZE_W) fill_q <= fill_q + AW1'(1);
      end
    end
  end

  assign SAMPLE_OUT = sample_out_q;
  assign OUT_VALID  = out_valid_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_WADDR  = mem_waddr_q;
  assign MEM_RADDR  = mem_raddr_q;
  assign MEM_DI     = mem_di_q;

endmodule
